// File: rtl/fc_pkg.sv
// fc_pkg: shared readout FSM states and accumulator width helper
package fc_pkg;
  typedef enum logic [1:0] {IDLE, ADDR, CAP, OUT} state_t;
  function automatic int acc_width(input int obuf_w, input int v_tiles);
    return obuf_w + $clog2(v_tiles);
  endfunction
endpackage

// File: rtl/fc_act_quant.sv
// fc_act_quant: optional ReLU, arithmetic right shift and saturation of an accumulated sum
module fc_act_quant #(
  parameter int ACC_W = 28,
  parameter int OUT_DATA_SIZE = 8
) (
  input  logic signed [ACC_W-1:0]         acc,
  input  logic                            relu,
  input  logic [4:0]                      shift,
  output logic signed [OUT_DATA_SIZE-1:0] data
);
  localparam int MAX_I = 2 ** (OUT_DATA_SIZE - 1) - 1;
  localparam logic signed [ACC_W-1:0] MAX = ACC_W'(MAX_I);
  localparam logic signed [ACC_W-1:0] MIN = ACC_W'(-MAX_I - 1);
  logic signed [ACC_W-1:0] r, s;
  // clamp negatives under ReLU, shift (sign-filling past the width), then clip to output range
  always_comb begin
    r = (relu && acc < 0) ? '0 : acc;
    s = r >>> shift;
    data = s > MAX ? OUT_DATA_SIZE'(MAX) : s < MIN ? OUT_DATA_SIZE'(MIN) : s[OUT_DATA_SIZE-1:0];
  end
endmodule

// File: rtl/fc_reduce_act.sv
// fc_reduce_act: reduces vertical CIM tile partial sums per neuron and streams requantised activations
module fc_reduce_act
  import fc_pkg::*;
#(
  parameter int V_TILES = 8,
  parameter int H_TILES = 2,
  parameter int COLS_PER_TILE = 64,
  parameter int OUTPUT_NEURONS = 100,
  parameter int OBUF_DATA_SIZE = 25,
  parameter int OUT_DATA_SIZE = 8
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        i_start,
  input  logic                                        i_relu_en,
  input  logic [4:0]                                  i_shift,
  output logic                                        o_busy,
  output logic [$clog2(COLS_PER_TILE)-1:0]            o_cim_rd_addr,
  input  logic [V_TILES*H_TILES*OBUF_DATA_SIZE-1:0]   i_data,
  output logic                                        o_valid,
  input  logic                                        i_next_ready,
  output logic signed [OUT_DATA_SIZE-1:0]             o_data,
  output logic [$clog2(OUTPUT_NEURONS)-1:0]           o_idx,
  output logic                                        o_last,
  output logic                                        o_done
);
  localparam int ACC_W = acc_width(OBUF_DATA_SIZE, V_TILES);
  localparam int ADDR_W = $clog2(COLS_PER_TILE);
  localparam int IDX_W = $clog2(OUTPUT_NEURONS);
  state_t state, state_n;
  logic [IDX_W-1:0] n, n_nx;
  logic relu;
  logic [4:0] shift;
  logic signed [ACC_W-1:0] acc, sum;
  logic is_last, xfer;
  assign is_last = n == IDX_W'(OUTPUT_NEURONS - 1);
  assign xfer = state == OUT && i_next_ready;
  assign o_busy = state != IDLE;
  assign o_valid = state == OUT;
  assign o_last = o_valid && is_last;
  assign o_idx = n;
  // sequence ADDR -> CAP -> OUT per neuron; a start landing on the done pulse is ignored
  always_comb begin
    state_n = state;
    n_nx = n;
    if (state == IDLE && i_start && !o_done) begin
      state_n = ADDR;
      n_nx = '0;
    end else if (state == ADDR) state_n = CAP;
    else if (state == CAP) state_n = OUT;
    else if (xfer) begin
      state_n = is_last ? IDLE : ADDR;
      n_nx = is_last ? n : n + 1'b1;
    end
  end
  // sum the V words of the H tile that owns the current neuron, sign-extended to ACC_W
  always_comb begin
    sum = '0;
    for (int v = 0; v < V_TILES; v++)
      sum = sum + ACC_W'($signed(i_data[(int'(n) / COLS_PER_TILE * V_TILES + v) * OBUF_DATA_SIZE +: OBUF_DATA_SIZE]));
  end
  // state, counter, latched config, read address, captured sum and done pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      n <= '0;
      relu <= 1'b0;
      shift <= '0;
      o_cim_rd_addr <= '0;
      acc <= '0;
      o_done <= 1'b0;
    end else begin
      state <= state_n;
      n <= n_nx;
      if (state == IDLE && state_n == ADDR) begin
        relu <= i_relu_en;
        shift <= i_shift;
      end
      if (state_n == ADDR) o_cim_rd_addr <= ADDR_W'(int'(n_nx) % COLS_PER_TILE);
      if (state == CAP) acc <= sum;
      o_done <= xfer && is_last;
    end
  end
  fc_act_quant #(.ACC_W(ACC_W), .OUT_DATA_SIZE(OUT_DATA_SIZE)) u_quant (
    .acc(acc),
    .relu(relu),
    .shift(shift),
    .data(o_data)
  );
endmodule

// File: tb/tb_fc_reduce_act.sv
// tb_fc_reduce_act: directed checks of reduction, activation, handshake, reset and start handling
module tb_fc_reduce_act;
  localparam int V = 8, H = 2, C = 64, N = 100, W = 25, O = 8;
  logic clk = 0, rst = 0, i_start = 0, i_relu_en = 0, i_next_ready = 1;
  logic [4:0] i_shift = 0;
  logic [V*H*W-1:0] i_data;
  logic o_busy, o_valid, o_last, o_done;
  logic [5:0] o_cim_rd_addr;
  logic signed [O-1:0] o_data;
  logic [6:0] o_idx;
  logic signed [W-1:0] mem [H][C][V];
  int checks = 0, errors = 0;
  int got_data[N], got_idx[N], got_last[N];
  int ntx, dcyc, ltx, viol, stall_cnt, stall_chg, busy1, busy_done;

  always #5 clk = ~clk;

  fc_reduce_act dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_relu_en(i_relu_en), .i_shift(i_shift),
    .o_busy(o_busy), .o_cim_rd_addr(o_cim_rd_addr), .i_data(i_data), .o_valid(o_valid),
    .i_next_ready(i_next_ready), .o_data(o_data), .o_idx(o_idx), .o_last(o_last), .o_done(o_done)
  );

  // CIM output buffers: words appear one cycle after the address
  always @(posedge clk)
    for (int h = 0; h < H; h++)
      for (int v = 0; v < V; v++)
        i_data[(h*V+v)*W +: W] <= mem[h][o_cim_rd_addr][v];

  task automatic fill(input int val);
    for (int h = 0; h < H; h++)
      for (int c = 0; c < C; c++)
        for (int v = 0; v < V; v++) mem[h][c][v] = W'(val);
  endtask

  task automatic run_layer(input logic relu, input logic [4:0] sh, input int stall_idx, input int stall_len, input logic keep);
    int hd, hi;
    ntx = 0; dcyc = -1; ltx = -1; viol = 0; stall_cnt = 0; stall_chg = 0; busy_done = -1;
    hd = 0; hi = 0;
    for (int i = 0; i < N; i++) begin got_data[i] = -999; got_idx[i] = -1; got_last[i] = -1; end
    i_next_ready = 1;
    @(negedge clk); i_relu_en = relu; i_shift = sh; i_start = 1;
    @(negedge clk); i_start = keep;
    busy1 = o_busy;
    for (int c = 1; c <= 2000; c++) begin
      if (o_valid && o_done) viol++;
      if (o_done) begin dcyc = c; busy_done = o_busy; break; end
      i_next_ready = !(o_valid && int'(o_idx) == stall_idx && stall_cnt < stall_len);
      if (!i_next_ready) begin
        if (stall_cnt == 0) begin hd = o_data; hi = o_idx; end
        else if (int'(o_data) != hd || int'(o_idx) != hi || !o_valid) stall_chg++;
        stall_cnt++;
      end
      if (o_valid && i_next_ready) begin
        if (ntx < N) begin got_data[ntx] = o_data; got_idx[ntx] = o_idx; got_last[ntx] = o_last; end
        ntx++; ltx = c;
      end
      @(negedge clk);
    end
    i_next_ready = 1;
  endtask

  task automatic test_reset;
    rst = 0;
    repeat (2) @(negedge clk);
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0d want 0", o_busy); end
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0d want 0", o_valid); end
    checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL reset_done got %0d want 0", o_done); end
    checks++; if (o_last !== 1'b0) begin errors++; $display("FAIL reset_last got %0d want 0", o_last); end
    checks++; if (o_data !== 8'sd0) begin errors++; $display("FAIL reset_data got %0d want 0", o_data); end
    checks++; if (o_idx !== 7'd0) begin errors++; $display("FAIL reset_idx got %0d want 0", o_idx); end
    checks++; if (o_cim_rd_addr !== 6'd0) begin errors++; $display("FAIL reset_addr got %0d want 0", o_cim_rd_addr); end
    rst = 1;
  endtask

  task automatic test_full_readout;
    fill(1);
    run_layer(0, 0, -1, 0, 0);
    checks++; if (ntx !== 100) begin errors++; $display("FAIL full_ntx got %0d want 100", ntx); end
    checks++; if (dcyc !== 301) begin errors++; $display("FAIL full_done_cycle got %0d want 301", dcyc); end
    checks++; if (ltx !== 300) begin errors++; $display("FAIL full_last_xfer got %0d want 300", ltx); end
    checks++; if (viol !== 0) begin errors++; $display("FAIL full_valid_with_done got %0d want 0", viol); end
    checks++; if (busy1 !== 1) begin errors++; $display("FAIL full_busy_start got %0d want 1", busy1); end
    checks++; if (busy_done !== 0) begin errors++; $display("FAIL full_busy_at_done got %0d want 0", busy_done); end
    for (int i = 0; i < N; i++) begin
      checks++; if (got_data[i] !== 8) begin errors++; $display("FAIL full_data[%0d] got %0d want 8", i, got_data[i]); end
      checks++; if (got_idx[i] !== i) begin errors++; $display("FAIL full_idx[%0d] got %0d want %0d", i, got_idx[i], i); end
      checks++; if (got_last[i] !== (i == N-1 ? 1 : 0)) begin errors++; $display("FAIL full_last[%0d] got %0d want %0d", i, got_last[i], i == N-1); end
    end
  endtask

  task automatic test_relu_mix;
    fill(1);
    for (int v = 0; v < V; v++) mem[1][6][v] = 0;
    mem[1][6][0] = 100;
    mem[1][6][1] = -300;
    run_layer(1, 2, -1, 0, 0);
    checks++; if (got_data[70] !== 0) begin errors++; $display("FAIL relu_neg got %0d want 0", got_data[70]); end
    checks++; if (got_idx[70] !== 70) begin errors++; $display("FAIL relu_idx got %0d want 70", got_idx[70]); end
    checks++; if (got_data[69] !== 2) begin errors++; $display("FAIL relu_pos got %0d want 2", got_data[69]); end
    run_layer(0, 2, -1, 0, 0);
    checks++; if (got_data[70] !== -50) begin errors++; $display("FAIL norelu_neg got %0d want -50", got_data[70]); end
    checks++; if (got_data[71] !== 2) begin errors++; $display("FAIL norelu_pos got %0d want 2", got_data[71]); end
  endtask

  task automatic test_saturate;
    fill(0);
    mem[0][3][0] = 40000;
    mem[0][4][0] = -40000;
    mem[0][5][1] = -16;
    run_layer(0, 4, -1, 0, 0);
    checks++; if (got_data[3] !== 127) begin errors++; $display("FAIL sat_pos got %0d want 127", got_data[3]); end
    checks++; if (got_data[4] !== -128) begin errors++; $display("FAIL sat_neg got %0d want -128", got_data[4]); end
    checks++; if (got_data[5] !== -1) begin errors++; $display("FAIL shift_neg got %0d want -1", got_data[5]); end
    checks++; if (got_data[0] !== 0) begin errors++; $display("FAIL zero_sum got %0d want 0", got_data[0]); end
    run_layer(1, 4, -1, 0, 0);
    checks++; if (got_data[4] !== 0) begin errors++; $display("FAIL sat_relu got %0d want 0", got_data[4]); end
    run_layer(0, 30, -1, 0, 0);
    checks++; if (got_data[3] !== 0) begin errors++; $display("FAIL bigshift_pos got %0d want 0", got_data[3]); end
    checks++; if (got_data[4] !== -1) begin errors++; $display("FAIL bigshift_neg got %0d want -1", got_data[4]); end
  endtask

  task automatic test_stall;
    fill(0);
    for (int n = 0; n < N; n++) mem[n/C][n%C][0] = W'(n);
    run_layer(0, 0, 5, 10, 0);
    checks++; if (ntx !== 100) begin errors++; $display("FAIL stall_ntx got %0d want 100", ntx); end
    checks++; if (dcyc !== 311) begin errors++; $display("FAIL stall_done_cycle got %0d want 311", dcyc); end
    checks++; if (stall_cnt !== 10) begin errors++; $display("FAIL stall_cycles got %0d want 10", stall_cnt); end
    checks++; if (stall_chg !== 0) begin errors++; $display("FAIL stall_changed got %0d want 0", stall_chg); end
    for (int i = 0; i < N; i++) begin
      checks++; if (got_data[i] !== i) begin errors++; $display("FAIL stall_data[%0d] got %0d want %0d", i, got_data[i], i); end
      checks++; if (got_idx[i] !== i) begin errors++; $display("FAIL stall_idx[%0d] got %0d want %0d", i, got_idx[i], i); end
    end
  endtask

  task automatic test_reset_mid;
    int found, seen_done, seen_busy;
    found = 0; seen_done = 0; seen_busy = 0;
    fill(1);
    @(negedge clk); i_relu_en = 0; i_shift = 0; i_start = 1;
    @(negedge clk); i_start = 0;
    for (int c = 0; c < 500 && !found; c++) begin
      if (o_valid && o_idx == 7'd40) found = 1;
      else @(negedge clk);
    end
    checks++; if (found !== 1) begin errors++; $display("FAIL mid_reach40 got %0d want 1", found); end
    #2 rst = 0;
    #1;
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL mid_busy got %0d want 0", o_busy); end
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL mid_valid got %0d want 0", o_valid); end
    checks++; if (o_data !== 8'sd0) begin errors++; $display("FAIL mid_data got %0d want 0", o_data); end
    checks++; if (o_idx !== 7'd0) begin errors++; $display("FAIL mid_idx got %0d want 0", o_idx); end
    checks++; if (o_cim_rd_addr !== 6'd0) begin errors++; $display("FAIL mid_addr got %0d want 0", o_cim_rd_addr); end
    repeat (2) @(negedge clk);
    rst = 1;
    repeat (20) begin
      @(negedge clk);
      if (o_done) seen_done++;
      if (o_busy) seen_busy++;
    end
    checks++; if (seen_done !== 0) begin errors++; $display("FAIL mid_no_done got %0d want 0", seen_done); end
    checks++; if (seen_busy !== 0) begin errors++; $display("FAIL mid_idle got %0d want 0", seen_busy); end
    run_layer(0, 0, -1, 0, 0);
    checks++; if (got_idx[0] !== 0) begin errors++; $display("FAIL mid_restart_idx got %0d want 0", got_idx[0]); end
    checks++; if (ntx !== 100) begin errors++; $display("FAIL mid_restart_ntx got %0d want 100", ntx); end
    checks++; if (dcyc !== 301) begin errors++; $display("FAIL mid_restart_done got %0d want 301", dcyc); end
  endtask

  task automatic test_start_ignore;
    fill(1);
    run_layer(0, 0, -1, 0, 1);
    checks++; if (ntx !== 100) begin errors++; $display("FAIL ign_ntx got %0d want 100", ntx); end
    checks++; if (dcyc !== 301) begin errors++; $display("FAIL ign_done_cycle got %0d want 301", dcyc); end
    checks++; if (got_idx[99] !== 99) begin errors++; $display("FAIL ign_last_idx got %0d want 99", got_idx[99]); end
    @(negedge clk);
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL ign_done_start_busy got %0d want 0", o_busy); end
    checks++; if (o_cim_rd_addr !== 6'd35) begin errors++; $display("FAIL ign_addr_held got %0d want 35", o_cim_rd_addr); end
    @(negedge clk);
    i_start = 0;
    checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL ign_restart_busy got %0d want 1", o_busy); end
    checks++; if (o_cim_rd_addr !== 6'd0) begin errors++; $display("FAIL ign_restart_addr got %0d want 0", o_cim_rd_addr); end
    @(negedge clk); rst = 0;
    @(negedge clk); rst = 1;
  endtask

  initial begin
    test_reset;
    test_full_readout;
    test_relu_mix;
    test_saturate;
    test_stall;
    test_reset_mid;
    test_start_ignore;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
